// File: rtl/sd_spi_link.sv
// SPI-mode responder for the SD disk manager: turns single-cycle request strobes
// into mode-0 SPI byte sequences and returns the card's reply byte with a rdy pulse.
module sd_spi_link #(
    parameter int CLK_DIV    = 4,
    parameter int POLL_MAX   = 8,
    parameter int INIT_BYTES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cmdx,
    input  logic [31:0] argx,
    input  logic        start40x,
    input  logic        startx,
    input  logic        readit,
    input  logic        init,
    input  logic        closex,
    output logic [7:0]  out,
    output logic        rdy,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [7:0]    POLL_N   = 8'(POLL_MAX);
    localparam logic [7:0]    INIT_N   = 8'(INIT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CMD, S_POLL_R1, S_WRBYTE, S_XFER, S_RDPOLL, S_CLOSE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ph_q, ph_d;
    logic [7:0]    bcnt_q, bcnt_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [5:0]    cmd_q, cmd_d;
    logic [31:0]   arg_q, arg_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic [7:0]    out_q, out_d;
    logic          rdy_q, rdy_d;

    logic          tick, fall_last, load, finish;
    logic [7:0]    load_byte, fin_out, bcnt_inc;

    function automatic logic [7:0] crc_byte(input logic [5:0] c);
        case (c)
            6'd0:    return 8'h95;
            6'd8:    return 8'h87;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [5:0] c,
                                              input logic [31:0] a);
        case (idx)
            3'd0:    return {2'b01, c};
            3'd1:    return a[31:24];
            3'd2:    return a[23:16];
            3'd3:    return a[15:8];
            3'd4:    return a[7:0];
            default: return crc_byte(c);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        bcnt_d    = bcnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        out_d     = out_q;
        rdy_d     = 1'b0;
        load      = 1'b0;
        load_byte = 8'hFF;
        finish    = 1'b0;
        fin_out   = rx_q;
        tick      = (cnt_q == DIV_LAST);
        fall_last = tick && (ph_q == 4'd15);
        bcnt_inc  = bcnt_q + 8'd1;

        // Byte engine: even half-periods end in a rising edge (sample miso),
        // odd ones in a falling edge (shift next mosi bit out).
        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                ph_d   = ph_q + 4'd1;
                sclk_d = ~ph_q[0];
                if (!ph_q[0]) begin
                    rx_d = {rx_q[6:0], miso};
                end else begin
                    mosi_d = tx_q[6];
                    tx_d   = {tx_q[6:0], 1'b1};
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                bcnt_d = 8'd0;
                if (init) begin
                    state_d = S_INIT;
                    cs_n_d  = 1'b1;
                    load    = 1'b1;
                end else if (closex) begin
                    state_d = S_CLOSE;
                    cs_n_d  = 1'b1;
                    load    = 1'b1;
                end else if (start40x && startx) begin
                    state_d   = S_WRBYTE;
                    cs_n_d    = 1'b0;
                    load      = 1'b1;
                    load_byte = argx[7:0];
                end else if (start40x) begin
                    state_d   = S_CMD;
                    cs_n_d    = 1'b0;
                    cmd_d     = cmdx;
                    arg_d     = argx;
                    load      = 1'b1;
                    load_byte = frame_byte(3'd0, cmdx, argx);
                end else if (startx && readit) begin
                    state_d = S_RDPOLL;
                    cs_n_d  = 1'b0;
                    load    = 1'b1;
                end else if (startx) begin
                    state_d = S_XFER;
                    cs_n_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            S_INIT: if (fall_last) begin
                if (bcnt_inc == INIT_N) begin
                    finish = 1'b1;
                end else begin
                    bcnt_d = bcnt_inc;
                    load   = 1'b1;
                end
            end
            S_CMD: if (fall_last) begin
                if (bcnt_q == 8'd5) begin
                    state_d = S_POLL_R1;
                    bcnt_d  = 8'd0;
                    load    = 1'b1;
                end else begin
                    bcnt_d    = bcnt_inc;
                    load      = 1'b1;
                    load_byte = frame_byte(bcnt_inc[2:0], cmd_q, arg_q);
                end
            end
            S_POLL_R1: if (fall_last) begin
                if (!rx_q[7]) begin
                    finish = 1'b1;
                end else if (bcnt_inc == POLL_N) begin
                    finish  = 1'b1;
                    fin_out = 8'hFF;
                end else begin
                    bcnt_d = bcnt_inc;
                    load   = 1'b1;
                end
            end
            S_RDPOLL: if (fall_last) begin
                if (rx_q != 8'hFF || bcnt_inc == POLL_N) begin
                    finish = 1'b1;
                end else begin
                    bcnt_d = bcnt_inc;
                    load   = 1'b1;
                end
            end
            default: if (fall_last) finish = 1'b1;
        endcase

        // Loading on the final falling edge chains bytes with no idle cycle.
        if (load) begin
            cnt_d  = '0;
            ph_d   = 4'd0;
            sclk_d = 1'b0;
            tx_d   = load_byte;
            mosi_d = load_byte[7];
        end
        if (finish) begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
            out_d   = fin_out;
            mosi_d  = 1'b1;
            sclk_d  = 1'b0;
            cnt_d   = '0;
            ph_d    = 4'd0;
            bcnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= 4'd0;
            bcnt_q  <= 8'd0;
            tx_q    <= 8'hFF;
            rx_q    <= 8'h00;
            cmd_q   <= 6'd0;
            arg_q   <= 32'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            out_q   <= 8'h00;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
        end
    end

    assign out  = out_q;
    assign rdy  = rdy_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;

endmodule

// File: tb/tb_sd_spi_link.sv
// Randomised scoreboard bench for sd_spi_link: a behavioural SD card drives miso
// and logs mosi bytes; a monitor checks bytes, chip select, out, rdy and latency.
`timescale 1ns/1ns
module tb_sd_spi_link;

    localparam int D  = 4;
    localparam int PM = 8;
    localparam int IB = 10;
    localparam int K_INIT = 0, K_CLOSE = 1, K_WR = 2, K_CMD = 3, K_RD = 4, K_XF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  cmdx = '0;
    logic [31:0] argx = '0;
    logic        start40x = 1'b0, startx = 1'b0, readit = 1'b0, init = 1'b0, closex = 1'b0;
    logic [7:0]  out;
    logic        rdy, sclk, mosi, miso, cs_n;

    int vecs = 0;
    int miscmp = 0;

    logic [7:0] resp_q[$];
    logic [7:0] got_mosi[$];
    logic [1:0] got_cs[$];
    logic [7:0] exp_mosi[$];
    logic       exp_cs[$];
    logic [7:0] exp_out[$];
    longint     acc_q[$];
    int         nb_q[$];

    sd_spi_link #(.CLK_DIV(D), .POLL_MAX(PM), .INIT_BYTES(IB)) dut (
        .clk(clk), .rst(rst), .cmdx(cmdx), .argx(argx), .start40x(start40x),
        .startx(startx), .readit(readit), .init(init), .closex(closex),
        .out(out), .rdy(rdy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        vecs++;
        if (act < lo || act > hi) begin
            miscmp++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [7:0] rsp(input logic [7:0] r[$], input int i);
        return (i < r.size()) ? r[i] : 8'hFF;
    endfunction

    // Behavioural SD card: one reply byte per transferred byte, 0xFF once its list runs dry.
    initial begin : card
        logic [7:0] ctx, rsh;
        int tbits, rbits;
        logic loaded, prev_s, cs_or, cs_and;
        miso = 1'b1; ctx = 8'hFF; rsh = 8'h00; tbits = 0; rbits = 0;
        loaded = 1'b0; prev_s = 1'b0; cs_or = 1'b0; cs_and = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                miso = 1'b1; tbits = 0; rbits = 0; loaded = 1'b0; prev_s = 1'b0;
                cs_or = 1'b0; cs_and = 1'b1;
            end else begin
                if (sclk && !prev_s) begin
                    if (!loaded) begin ctx = 8'hFF; loaded = 1'b1; end
                    rsh = {rsh[6:0], mosi};
                    cs_or = cs_or | cs_n;
                    cs_and = cs_and & cs_n;
                    rbits++;
                    if (rbits == 8) begin
                        got_mosi.push_back(rsh);
                        got_cs.push_back({cs_or, cs_and});
                        rbits = 0; cs_or = 1'b0; cs_and = 1'b1;
                    end
                end else if (!sclk && prev_s) begin
                    tbits++;
                    if (tbits == 8) begin
                        tbits = 0; loaded = 1'b0; miso = 1'b1;
                    end else begin
                        ctx = {ctx[6:0], 1'b1}; miso = ctx[7];
                    end
                end
                if (!loaded && resp_q.size() > 0) begin
                    ctx = resp_q.pop_front(); loaded = 1'b1; miso = ctx[7];
                end
                prev_s = sclk;
            end
        end
    end

    initial begin : monitor
        logic [7:0] last_out, e, g;
        logic [1:0] gc;
        logic ec, prev_rdy;
        longint ta;
        int nb, lat;
        last_out = 8'h00; prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_sclk", sclk, 0);
                chk("rst_mosi", mosi, 1);
                chk("rst_cs_n", cs_n, 1);
                chk("rst_rdy", rdy, 0);
                chk("rst_out", out, 0);
                last_out = 8'h00; prev_rdy = 1'b0;
            end else begin
                if (prev_rdy) chk("rdy_width", rdy, 0);
                if (rdy) begin
                    if (exp_out.size() == 0) begin
                        vecs++; miscmp++;
                        $display("FAIL unexpected_rdy: got rdy=1 with out=%0h, expected no rdy", out);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out", out, e);
                        last_out = e;
                        ta = acc_q.pop_front();
                        nb = nb_q.pop_front();
                        lat = int'((longint'($time) - 5 - ta) / 10);
                        if (nb == 1) chk("latency", lat, 16 * D);
                        else chk_range("latency", lat, nb * 16 * D, nb * 16 * D + nb - 1);
                    end
                end else begin
                    chk("out_hold", out, last_out);
                end
                prev_rdy = rdy;
            end
            while (got_mosi.size() > 0) begin
                g = got_mosi.pop_front();
                gc = got_cs.pop_front();
                if (exp_mosi.size() == 0) begin
                    vecs++; miscmp++;
                    $display("FAIL extra_spi_byte: got %0h, expected no transfer", g);
                end else begin
                    e = exp_mosi.pop_front();
                    ec = exp_cs.pop_front();
                    chk("mosi_byte", g, e);
                    chk("cs_n_during_byte", gc, {ec, ec});
                end
            end
        end
    end

    // Reference model: derives the mosi byte list, chip-select level and reply from the card replies.
    task automatic run_req(input int kind, input logic [5:0] c, input logic [31:0] a,
                           input logic [7:0] r[$]);
        logic [7:0] tx[$];
        logic [7:0] o, b;
        logic csv;
        int n, bound;
        csv = 1'b0; o = 8'hFF;
        case (kind)
            K_INIT: begin
                csv = 1'b1;
                for (int i = 0; i < IB; i++) tx.push_back(8'hFF);
                o = rsp(r, IB - 1);
            end
            K_CLOSE: begin csv = 1'b1; tx.push_back(8'hFF); o = rsp(r, 0); end
            K_WR:    begin tx.push_back(a[7:0]); o = rsp(r, 0); end
            K_XF:    begin tx.push_back(8'hFF); o = rsp(r, 0); end
            K_RD: begin
                n = 0;
                do begin
                    tx.push_back(8'hFF); o = rsp(r, n); n++;
                end while (o == 8'hFF && n < PM);
            end
            default: begin
                tx.push_back({2'b01, c});
                tx.push_back(a[31:24]); tx.push_back(a[23:16]);
                tx.push_back(a[15:8]);  tx.push_back(a[7:0]);
                tx.push_back(c == 6'd0 ? 8'h95 : (c == 6'd8 ? 8'h87 : 8'h01));
                for (int k = 0; k < PM; k++) begin
                    tx.push_back(8'hFF);
                    b = rsp(r, 6 + k);
                    if (!b[7]) begin o = b; break; end
                end
            end
        endcase
        foreach (tx[i]) begin
            exp_mosi.push_back(tx[i]);
            exp_cs.push_back(csv);
            resp_q.push_back(rsp(r, i));
        end
        exp_out.push_back(o);
        nb_q.push_back(tx.size());

        @(posedge clk); #1;
        cmdx = c; argx = a;
        init     = (kind == K_INIT);
        closex   = (kind == K_CLOSE);
        start40x = (kind == K_WR || kind == K_CMD);
        startx   = (kind == K_WR || kind == K_RD || kind == K_XF);
        readit   = (kind == K_RD);
        @(posedge clk);
        acc_q.push_back(longint'($time));
        #1;
        init = 1'b0; closex = 1'b0; start40x = 1'b0; startx = 1'b0; readit = 1'b0;

        bound = tx.size() * (16 * D + 1) + 40;
        n = 0;
        while (rdy !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        if (rdy !== 1'b1) begin
            vecs++; miscmp++;
            $display("FAIL rdy_timeout: no rdy after %0d cycles, expected rdy", n);
        end
        @(posedge clk);
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin : stim
        logic [7:0] r[$];
        logic [5:0] c;
        logic [31:0] a;
        int kind, nterm;

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        r = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        run_req(K_CMD, 6'd17, 32'h0000_0010, r);
        r = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        run_req(K_CMD, 6'd0, 32'h0, r);
        run_req(K_CMD, 6'd8, 32'h0000_01AA, r);
        r.delete();
        run_req(K_CMD, 6'd55, 32'h1234_5678, r);
        r = '{8'h05};
        run_req(K_WR, 6'd0, 32'h0000_00A5, r);
        r = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3C};
        run_req(K_INIT, 6'd0, 32'h0, r);
        r = '{8'h7E};
        run_req(K_CLOSE, 6'd0, 32'h0, r);

        // Abort a CMD frame with reset during its third byte; a stray startx before that must be ignored.
        for (int i = 0; i < 6; i++) resp_q.push_back(8'hFF);
        exp_mosi.push_back(8'h40 | 8'd24); exp_cs.push_back(1'b0);
        exp_mosi.push_back(8'hDE);         exp_cs.push_back(1'b0);
        @(posedge clk); #1;
        cmdx = 6'd24; argx = 32'hDEAD_BEEF; start40x = 1'b1;
        @(posedge clk); #1 start40x = 1'b0;
        repeat (20 * D - 1) @(posedge clk);
        #1 startx = 1'b1;
        @(posedge clk); #1 startx = 1'b0;
        repeat (20 * D - 1) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        resp_q.delete();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        r = '{8'h9A};
        run_req(K_XF, 6'd0, 32'h0, r);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 11);
            kind = (kind < 1) ? K_INIT : (kind < 2) ? K_CLOSE : (kind < 4) ? K_WR :
                   (kind < 7) ? K_CMD : (kind < 10) ? K_RD : K_XF;
            c = ($urandom_range(0, 3) == 0) ? 6'd0 :
                ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
            a = $urandom;
            r.delete();
            nterm = $urandom_range(0, PM + 1);
            if (kind == K_CMD) begin
                for (int i = 0; i < 6; i++) r.push_back(8'($urandom));
                for (int i = 0; i < nterm; i++) r.push_back(8'($urandom) | 8'h80);
                r.push_back(8'($urandom) & 8'h7F);
            end else if (kind == K_RD) begin
                for (int i = 0; i < nterm; i++) r.push_back(8'hFF);
                r.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : (8'($urandom) & 8'hFE));
            end else begin
                for (int i = 0; i < IB; i++) r.push_back(8'($urandom));
            end
            run_req(kind, c, a, r);
        end

        repeat (50) @(posedge clk);
        chk("pending_replies", exp_out.size(), 0);
        chk("pending_spi_bytes", exp_mosi.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
